counter_load_arbiter: RTL and testbench

- Round-robin arbiter that shares the 8-bit loadable counter's load port among NUM_REQ requesters.
- Each granted request produces a correctly formed load_n sequence on the counter's load input:
  - a one-cycle setup with load_n high,
  - a low pulse, which the counter detects as a synchronous falling edge,
  - a recovery gap with load_n high.
- While the sequence runs, the block drives the winning requester's value onto the counter's shared data bus.
- Sits between the on-chip requesters and the counter's load_n, data and bus-enable pins.

---
 rtl/counter_load_arbiter_if.sv | 26 ++
 rtl/counter_load_arbiter.sv | 120 ++++++++++++
 tb/tb_counter_load_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_load_arbiter_if.sv
// Load-port bundle between the requesters and the counter: requests and data in,
// load strobe, data bus and acknowledges out.
interface counter_load_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      hold;
  logic [NUM_REQ-1:0]        ack;
  logic                      load_n;
  logic [DATA_W-1:0]         load_data;
  logic                      bus_oe;
  logic                      busy;

  // master is the arbiter driving the counter; slave is the requester/counter side
  modport master (
    input  req, req_data, hold,
    output ack, load_n, load_data, bus_oe, busy
  );

  modport slave (
    output req, req_data, hold,
    input  ack, load_n, load_data, bus_oe, busy
  );
endinterface

// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter sharing the counter load port: each grant emits a one-cycle setup,
// a load_n low pulse and a recovery gap while driving the winner's value on the data bus.
module counter_load_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned LOAD_LOW_CYCLES = 1,
  parameter int unsigned GAP_CYCLES      = 1
) (
  input logic                    clk,
  input logic                    rst,
  counter_load_arbiter_if.master bus
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MaxCyc = (LOAD_LOW_CYCLES > GAP_CYCLES) ? LOAD_LOW_CYCLES
                                                                   : GAP_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] LoadLast = CntW'(LOAD_LOW_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StLoad, StRecover} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     win_q;
  logic [IdxW-1:0]     ptr_q;
  logic                load_n_q;
  logic                bus_oe_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REQ-1:0]  ack_q;

  logic [IdxW-1:0]     pick;
  logic [IdxW-1:0]     cand;
  logic                found;
  logic                start;
  logic [DATA_W-1:0]   req_vals [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_vals
    assign req_vals[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  // First set request scanning upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = (cand == IdxMax) ? '0 : cand + 1'b1;
    end
  end

  // Arbitration also happens on the last recovery cycle so back-to-back loads
  // see only RECOVER plus SETUP as high time between pulses.
  assign start = found && !bus.hold &&
                 ((state_q == StIdle) || ((state_q == StRecover) && (cnt_q == GapLast)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      win_q    <= '0;
      ptr_q    <= '0;
      load_n_q <= 1'b1;
      bus_oe_q <= 1'b0;
      data_q   <= '0;
      ack_q    <= '0;
    end else begin
      ack_q <= '0;
      if (start) begin
        state_q  <= StSetup;
        win_q    <= pick;
        data_q   <= req_vals[pick];
        bus_oe_q <= 1'b1;
        cnt_q    <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StSetup: begin
            state_q  <= StLoad;
            load_n_q <= 1'b0;
            cnt_q    <= '0;
          end
          StLoad: begin
            if (cnt_q == LoadLast) begin
              state_q      <= StRecover;
              load_n_q     <= 1'b1;
              bus_oe_q     <= 1'b0;
              ack_q[win_q] <= 1'b1;
              ptr_q        <= (win_q == IdxMax) ? '0 : win_q + 1'b1;
              cnt_q        <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StRecover: begin
            if (cnt_q == GapLast) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.ack       = ack_q;
  assign bus.load_n    = load_n_q;
  assign bus.load_data = data_q;
  assign bus.bus_oe    = bus_oe_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Bench for counter_load_arbiter: a default instance and a LOAD_LOW_CYCLES=3/GAP_CYCLES=2
// instance, each feeding a behavioural 8-bit counter, checked against a timeline model.
module tb_counter_load_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  counter_load_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) a ();
  counter_load_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b ();

  counter_load_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .LOAD_LOW_CYCLES(1), .GAP_CYCLES(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(a));

  counter_load_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .LOAD_LOW_CYCLES(3), .GAP_CYCLES(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(b));

  int n_cmp = 0;
  int n_err = 0;
  bit sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: position within a granted sequence (0=setup, 1..L=low, L+1..L+G=recover).
  typedef struct {
    int         pos;
    int         ptr;
    int         win;
    logic [7:0] data;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pos = -1; m.ptr = 0; m.win = 0; m.data = 8'h00;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r, input logic [31:0] d,
                                    input logic h, input int L, input int G);
    mdl_t n = m;
    bit   got = 1'b0;
    if (m.pos < 0 || m.pos == L + G) begin
      n.pos = -1;
      if (!h) begin
        for (int k = 0; k < 4; k++) begin
          int i = (m.ptr + k) % 4;
          if (!got && r[i]) begin
            got = 1'b1; n.win = i; n.data = d[i*8 +: 8]; n.pos = 0;
          end
        end
      end
    end else begin
      n.pos = m.pos + 1;
      if (n.pos == L + 1) n.ptr = (m.win + 1) % 4;
    end
    return n;
  endfunction

  mdl_t m_a, m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= mdl_reset();
      m_b <= mdl_reset();
    end else begin
      m_a <= mdl_step(m_a, a.req, a.req_data, a.hold, 1, 1);
      m_b <= mdl_step(m_b, b.req, b.req_data, b.hold, 3, 2);
    end
  end

  task automatic cmp_bus(input string tag, input mdl_t m, input int L, input logic [3:0] ack,
                         input logic ln, input logic oe, input logic bsy, input logic [7:0] ld);
    check({tag, "_load_n"}, 32'(ln), 32'(!(m.pos >= 1 && m.pos <= L)));
    check({tag, "_bus_oe"}, 32'(oe), 32'(m.pos >= 0 && m.pos <= L));
    check({tag, "_busy"}, 32'(bsy), 32'(m.pos >= 0));
    check({tag, "_ack"}, 32'(ack), (m.pos == L + 1) ? (32'd1 << m.win) : 32'd0);
    check({tag, "_load_data"}, 32'(ld), 32'(m.data));
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      cmp_bus("sb_a", m_a, 1, a.ack, a.load_n, a.bus_oe, a.busy, a.load_data);
      cmp_bus("sb_b", m_b, 3, b.ack, b.load_n, b.bus_oe, b.busy, b.load_data);
    end
  end

  // Behavioural counters: load on a sampled falling edge of load_n, else count up.
  logic [7:0] cnt_a, cnt_b;
  int lo_a, hi_a, gap_a, nfall_a, lo_b, hi_b, gap_b, nfall_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0; lo_a <= 0; hi_a <= 0; gap_a <= 0; nfall_a <= 0;
      cnt_b <= '0; lo_b <= 0; hi_b <= 0; gap_b <= 0; nfall_b <= 0;
    end else begin
      if (a.load_n) begin
        if (lo_a != 0) check("a_low_width", 32'(lo_a), 32'd1);
        lo_a <= 0; hi_a <= hi_a + 1; cnt_a <= cnt_a + 8'd1;
      end else begin
        if (lo_a == 0) begin
          gap_a <= hi_a; nfall_a <= nfall_a + 1; cnt_a <= a.load_data;
        end else cnt_a <= cnt_a + 8'd1;
        lo_a <= lo_a + 1; hi_a <= 0;
      end
      if (b.load_n) begin
        if (lo_b != 0) check("b_low_width", 32'(lo_b), 32'd3);
        lo_b <= 0; hi_b <= hi_b + 1; cnt_b <= cnt_b + 8'd1;
      end else begin
        if (lo_b == 0) begin
          gap_b <= hi_b; nfall_b <= nfall_b + 1; cnt_b <= b.load_data;
        end else cnt_b <= cnt_b + 8'd1;
        lo_b <= lo_b + 1; hi_b <= 0;
      end
    end
  end

  task automatic do_reset();
    a.req = '0; a.req_data = '0; a.hold = 1'b0;
    b.req = '0; b.req_data = '0; b.hold = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit on_b, output int idx);
    idx = -1;
    for (int c = 0; c < 40 && idx < 0; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (!on_b && a.ack[i]) idx = i;
        if (on_b && b.ack[i]) idx = i;
      end
    end
  endtask

  task automatic wait_low_a();
    for (int c = 0; c < 40 && a.load_n; c++) begin
      @(posedge clk); #1;
    end
    check("wait_load_low", 32'(a.load_n), 32'd0);
  endtask

  function automatic logic [3:0] next_req(input logic [3:0] r, input logic [3:0] ack);
    logic [3:0] n = r;
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) n[i] = 1'b0;
      else if (!r[i] && $urandom_range(2) == 0) n[i] = 1'b1;
      else if (r[i] && $urandom_range(31) == 0) n[i] = 1'b0;
    end
    return n;
  endfunction

  typedef struct {
    logic [3:0] pre;
    logic [3:0] req;
    int         w1;
    int         w2;
  } vec_t;

  vec_t vecs[8];
  int   got;

  initial begin
    vecs[0] = '{pre: 4'b0000, req: 4'b0001, w1: 0, w2: -1};
    vecs[1] = '{pre: 4'b0000, req: 4'b0110, w1: 1, w2: 2};
    vecs[2] = '{pre: 4'b0000, req: 4'b1000, w1: 3, w2: -1};
    vecs[3] = '{pre: 4'b0000, req: 4'b1111, w1: 0, w2: 1};
    vecs[4] = '{pre: 4'b0100, req: 4'b1001, w1: 3, w2: 0};
    vecs[5] = '{pre: 4'b1000, req: 4'b1001, w1: 0, w2: 3};
    vecs[6] = '{pre: 4'b0010, req: 4'b0011, w1: 0, w2: 1};
    vecs[7] = '{pre: 4'b0001, req: 4'b0011, w1: 1, w2: 0};

    a.req = '0; a.req_data = '0; a.hold = 1'b0;
    b.req = '0; b.req_data = '0; b.hold = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_load_n", 32'(a.load_n), 32'd1);
    check("rst_bus_oe", 32'(a.bus_oe), 32'd0);
    check("rst_load_data", 32'(a.load_data), 32'd0);
    check("rst_ack", 32'(a.ack), 32'd0);
    check("rst_busy", 32'(a.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_on = 1'b1;

    // Single load with counter follow-through.
    @(posedge clk); #1;
    a.req_data[7:0] = 8'hA5; a.req = 4'b0001;
    @(posedge clk); #1;
    check("sl_setup_load_n", 32'(a.load_n), 32'd1);
    check("sl_setup_oe", 32'(a.bus_oe), 32'd1);
    check("sl_setup_data", 32'(a.load_data), 32'hA5);
    @(posedge clk); #1;
    check("sl_load_n_low", 32'(a.load_n), 32'd0);
    @(posedge clk); #1;
    check("sl_ack", 32'(a.ack), 32'b0001);
    check("sl_cnt_load", 32'(cnt_a), 32'hA5);
    a.req = '0;
    @(posedge clk); #1;
    check("sl_ack_drop", 32'(a.ack), 32'd0);
    check("sl_cnt_a6", 32'(cnt_a), 32'hA6);
    @(posedge clk); #1;
    check("sl_cnt_a7", 32'(cnt_a), 32'hA7);

    // Table-driven priority and pointer-wrap vectors.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      a.req_data = {8'h35, 8'h25, 8'h15, 8'h05};
      if (vecs[v].pre != 4'b0000) begin
        a.req = vecs[v].pre;
        wait_ack(1'b0, got);
        a.req = '0;
        repeat (3) @(posedge clk);
        #1;
      end
      a.req = vecs[v].req;
      wait_ack(1'b0, got);
      check("vec_w1", 32'(got), 32'(vecs[v].w1));
      check("vec_cnt1", 32'(cnt_a), 32'(8'(16 * vecs[v].w1 + 5)));
      a.req = a.req & ~a.ack;
      if (vecs[v].w2 >= 0) begin
        wait_ack(1'b0, got);
        check("vec_w2", 32'(got), 32'(vecs[v].w2));
        check("vec_cnt2", 32'(cnt_a), 32'(8'(16 * vecs[v].w2 + 5)));
      end
      a.req = '0;
      repeat (8) @(posedge clk);
      #1;
    end

    // Round robin with all requesters held high.
    do_reset();
    a.req_data = {8'h30, 8'h20, 8'h10, 8'h00};
    a.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack(1'b0, got);
      check("rr_grant", 32'(got), 32'(j % 4));
      check("rr_cnt", 32'(cnt_a), 32'(8'(16 * (j % 4))));
      if (j > 0) check("rr_gap", 32'(gap_a), 32'd2);
    end
    check("rr_falls", 32'(nfall_a), 32'd5);
    a.req = '0;

    // hold during LOAD: in-flight load completes, no new setup until release.
    do_reset();
    a.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    a.req = 4'b0110;
    wait_low_a();
    a.hold = 1'b1;
    wait_ack(1'b0, got);
    check("hold_ack", 32'(got), 32'd1);
    a.req = 4'b0100;
    repeat (6) begin
      @(posedge clk); #1;
      check("hold_no_setup", 32'({a.busy, a.bus_oe}), 32'd0);
    end
    a.hold = 1'b0;
    @(posedge clk); #1;
    check("hold_resume_oe", 32'(a.bus_oe), 32'd1);
    check("hold_resume_data", 32'(a.load_data), 32'h33);
    wait_ack(1'b0, got);
    check("hold_resume_ack", 32'(got), 32'd2);
    a.req = '0;

    // Asynchronous reset in the middle of requester 1's LOAD.
    do_reset();
    a.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    a.req = 4'b0001;
    wait_ack(1'b0, got);
    a.req = 4'b0010;
    wait_low_a();
    #3 rst = 1'b1;
    #1;
    check("arst_load_n", 32'(a.load_n), 32'd1);
    check("arst_bus_oe", 32'(a.bus_oe), 32'd0);
    check("arst_busy", 32'(a.busy), 32'd0);
    check("arst_ack", 32'(a.ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a.req = 4'b0011;
    wait_ack(1'b0, got);
    check("arst_ptr0", 32'(got), 32'd0);
    a.req = a.req & ~a.ack;
    wait_ack(1'b0, got);
    check("arst_rearb", 32'(got), 32'd1);
    a.req = '0;

    // Longer pulse and gap on the second instance.
    do_reset();
    b.req_data = {8'h84, 8'h73, 8'h62, 8'h51};
    b.req = 4'b0011;
    wait_ack(1'b1, got);
    check("sweep_w0", 32'(got), 32'd0);
    check("sweep_cnt0", 32'(cnt_b), 32'h53);
    b.req = b.req & ~b.ack;
    wait_ack(1'b1, got);
    check("sweep_w1", 32'(got), 32'd1);
    check("sweep_cnt1", 32'(cnt_b), 32'h64);
    check("sweep_gap", 32'(gap_b), 32'd3);
    check("sweep_falls", 32'(nfall_b), 32'd2);
    b.req = '0;

    // Random traffic on both instances; the scoreboard checks every cycle.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      a.req = next_req(a.req, a.ack);
      b.req = next_req(b.req, b.ack);
      a.req_data = $urandom;
      b.req_data = $urandom;
      a.hold = ($urandom_range(7) == 0);
      b.hold = ($urandom_range(7) == 0);
    end
    a.req = '0; b.req = '0; a.hold = 1'b0; b.hold = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    sb_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
